// File: rtl/dbg_dpy_pkg.sv
// dbg_dpy_pkg: shared constants for the debug seven-segment display driver.
//   SEG_HEX   - nibble -> gfedcba segment pattern (active high)
//   SEG_BLANK - all segments off
//   SEG_A/SEG_G/SEG_DP - bit positions inside the 8-bit segment bus
//   mode_e    - channel-select mode of the display driver
package dbg_dpy_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [6:0] SEG_HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_AUTO   = 1'b1
    } mode_e;

endpackage

// File: rtl/dbg_dpy_mux_scan_if.sv
// dbg_dpy_mux_scan_if: bundle between debug sources and the display driver.
//   ch_data   - packed channel words, channel k at [k*4*DIGIT_CNT +: 4*DIGIT_CNT]
//   dp_mask   - per-digit decimal point enable (live)
//   ch_sel    - manual channel select
//   rotate_en - 1 = auto-rotate channels
//   freeze    - hold snapshot and pause rotation
//   digit     - one-hot digit enable, active high
//   segment   - [6:0] gfedcba, [7] dp, active high
//   cur_ch    - channel latched for display
// master drives the debug words, slave is the display driver.
interface dbg_dpy_mux_scan_if #(
    parameter int DIGIT_CNT   = 8,
    parameter int CH_CNT      = 4,
    parameter int LOG2_CH_CNT = (CH_CNT > 1) ? $clog2(CH_CNT) : 1
);
    logic [CH_CNT*4*DIGIT_CNT-1:0] ch_data;
    logic [DIGIT_CNT-1:0]          dp_mask;
    logic [LOG2_CH_CNT-1:0]        ch_sel;
    logic                          rotate_en;
    logic                          freeze;
    logic [DIGIT_CNT-1:0]          digit;
    logic [7:0]                    segment;
    logic [LOG2_CH_CNT-1:0]        cur_ch;

    modport master (
        output ch_data, dp_mask, ch_sel, rotate_en, freeze,
        input  digit, segment, cur_ch
    );

    modport slave (
        input  ch_data, dp_mask, ch_sel, rotate_en, freeze,
        output digit, segment, cur_ch
    );
endinterface

// File: rtl/dbg_dpy_hex7seg.sv
// dbg_dpy_hex7seg: combinational hex digit decoder.
//   nibble - 4-bit value
//   seg    - gfedcba pattern, active high
module dbg_dpy_hex7seg
    import dbg_dpy_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    always_comb begin
        seg = SEG_HEX[nibble];
    end
endmodule

// File: rtl/dbg_dpy_mux_scan.sv
// dbg_dpy_mux_scan: multi-channel debug word driver for a multiplexed
// seven-segment display. Selects a channel (manual or timed rotation),
// snapshots it once per frame and scans it out as hex, blanking the first
// BLANK_CYCLES of every digit dwell to suppress ghosting.
//   clock   - system clock
//   reset_n - asynchronous reset, active low
//   dpy     - dbg_dpy_mux_scan_if.slave (channel words, controls, pins)
// Optional: define DBG_DPY_LZ_BLANK_EN to blank leading zero digits
// (digit 0 always shown; dp and digit scanning unaffected).
module dbg_dpy_mux_scan
    import dbg_dpy_pkg::*;
#(
    parameter int DIGIT_CNT     = 8,
    parameter int CH_CNT        = 4,
    parameter int DWELL_CYCLES  = 12500,
    parameter int BLANK_CYCLES  = 16,
    parameter int ROTATE_CYCLES = 200000000,
    parameter int LOG2_CH_CNT   = (CH_CNT > 1) ? $clog2(CH_CNT) : 1
) (
    input logic               clock,
    input logic               reset_n,
    dbg_dpy_mux_scan_if.slave dpy
);
    localparam int WORD_W  = 4 * DIGIT_CNT;
    localparam int DWELL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int IDX_W   = (DIGIT_CNT > 1) ? $clog2(DIGIT_CNT) : 1;
    localparam int ROT_W   = (ROTATE_CYCLES > 1) ? $clog2(ROTATE_CYCLES) : 1;

    localparam logic [DWELL_W-1:0]     DWELL_LAST  = DWELL_W'(DWELL_CYCLES - 1);
    localparam logic [DWELL_W-1:0]     BLANK_END   = DWELL_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]       IDX_LAST    = IDX_W'(DIGIT_CNT - 1);
    localparam logic [ROT_W-1:0]       ROT_LAST    = ROT_W'(ROTATE_CYCLES - 1);
    localparam logic [LOG2_CH_CNT-1:0] CH_LAST     = LOG2_CH_CNT'(CH_CNT - 1);

    logic [DWELL_W-1:0]     dwell_q, dwell_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [ROT_W-1:0]       rot_q, rot_d;
    mode_e                  mode_q, mode_d;
    logic [LOG2_CH_CNT-1:0] active_q, active_d, active_now;
    logic [LOG2_CH_CNT-1:0] cur_ch_q, cur_ch_d;
    logic [WORD_W-1:0]      snap_q, snap_d;
    logic [DIGIT_CNT-1:0]   digit_q, digit_d;
    logic [7:0]             segment_q, segment_d;

    logic       frame_start;
    logic [3:0] nibble;
    logic       dp_bit;
    logic [6:0] hex_seg;
    logic       lz_blank;

    // Dwell / digit-index scan counters.
    always_comb begin
        dwell_d = dwell_q + 1'b1;
        idx_d   = idx_q;
        if (dwell_q == DWELL_LAST) begin
            dwell_d = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    // Channel mode FSM and rotate timer.
    always_comb begin
        mode_d   = dpy.rotate_en ? MODE_AUTO : MODE_MANUAL;
        rot_d    = '0;
        active_d = active_q;
        if (CH_CNT > 1) begin
            if (!dpy.rotate_en) begin
                if (dpy.ch_sel <= CH_LAST) begin
                    active_d = dpy.ch_sel;
                end
            end else if (mode_q == MODE_MANUAL) begin
                // rising edge of rotate_en: timer restarts, channel kept
                rot_d = '0;
            end else if (dpy.freeze) begin
                rot_d = rot_q;
            end else if (rot_q == ROT_LAST) begin
                rot_d    = '0;
                active_d = (active_q == CH_LAST) ? '0 : active_q + 1'b1;
            end else begin
                rot_d = rot_q + 1'b1;
            end
        end
        // Manual select takes effect in the same cycle; auto uses the register.
        active_now = dpy.rotate_en ? active_q : active_d;
    end

    // Frame snapshot: the only point where the displayed word/channel change.
    always_comb begin
        frame_start = (idx_q == '0) && (dwell_q == '0);
        snap_d      = snap_q;
        cur_ch_d    = cur_ch_q;
        if (frame_start && !dpy.freeze) begin
            cur_ch_d = active_now;
            for (int unsigned k = 0; k < CH_CNT; k++) begin
                if (active_now == LOG2_CH_CNT'(k)) begin
                    snap_d = dpy.ch_data[k*WORD_W +: WORD_W];
                end
            end
        end
    end

`ifdef DBG_DPY_LZ_BLANK_EN
    logic [IDX_W-1:0] lz_top;

    always_comb begin
        lz_top = '0;
        for (int unsigned i = 1; i < DIGIT_CNT; i++) begin
            if (snap_q[i*4 +: 4] != 4'h0) begin
                lz_top = IDX_W'(i);
            end
        end
        lz_blank = (idx_q > lz_top);
    end
`else
    always_comb begin
        lz_blank = 1'b0;
    end
`endif

    // Digit mux feeding the single decoder instance.
    always_comb begin
        nibble = 4'h0;
        dp_bit = 1'b0;
        for (int unsigned i = 0; i < DIGIT_CNT; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nibble = snap_q[i*4 +: 4];
                dp_bit = dpy.dp_mask[i];
            end
        end
    end

    dbg_dpy_hex7seg u_hex7seg (
        .nibble (nibble),
        .seg    (hex_seg)
    );

    always_comb begin
        digit_d   = '0;
        segment_d = '0;
        if (dwell_q >= BLANK_END) begin
            for (int unsigned i = 0; i < DIGIT_CNT; i++) begin
                digit_d[i] = (idx_q == IDX_W'(i));
            end
            segment_d[SEG_G:SEG_A] = lz_blank ? SEG_BLANK : hex_seg;
            segment_d[SEG_DP]      = dp_bit;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dwell_q   <= '0;
            idx_q     <= '0;
            rot_q     <= '0;
            mode_q    <= MODE_MANUAL;
            active_q  <= '0;
            cur_ch_q  <= '0;
            snap_q    <= '0;
            digit_q   <= '0;
            segment_q <= '0;
        end else begin
            dwell_q   <= dwell_d;
            idx_q     <= idx_d;
            rot_q     <= rot_d;
            mode_q    <= mode_d;
            active_q  <= active_d;
            cur_ch_q  <= cur_ch_d;
            snap_q    <= snap_d;
            digit_q   <= digit_d;
            segment_q <= segment_d;
        end
    end

    assign dpy.digit   = digit_q;
    assign dpy.segment = segment_q;
    assign dpy.cur_ch  = cur_ch_q;

endmodule
